rand_pq_driver: RTL

- Controller that sequences the team's external 8-bit LFSR to produce randomized operation streams for priority-queue stress testing.
- Steps the LFSR one byte at a time. Uses one byte to choose enqueue or dequeue, and two more bytes to build a 16-bit key.
- Issues each operation to the priority queue over a valid/ready handshake, until a programmed operation count is reached.
- Sits between the LFSR instance and the priority-queue command port in the test harness.

---
 rtl/rand_pq_pkg.sv | 21 ++
 rtl/rand_pq_driver.sv | 105 ++++++++++
 2 files changed

// File: rtl/rand_pq_pkg.sv
// Shared types for the randomized priority-queue stimulus driver.
package rand_pq_pkg;

  localparam int unsigned KEY_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StDecide,
    StKeyHi,
    StKeyLo,
    StIssue,
    StDone
  } drv_state_t;

  typedef struct packed {
    logic             enq;
    logic [KEY_W-1:0] key;
  } pq_op_t;

endpackage

// File: rtl/rand_pq_driver.sv
// Steps an external 8-bit LFSR to build enqueue/dequeue operations and issues them to a
// priority queue over valid/ready until NUM_OPS handshakes have completed.
module rand_pq_driver
  import rand_pq_pkg::*;
#(
  parameter int unsigned       NUM_OPS    = 64,
  parameter logic [BYTE_W-1:0] ENQ_THRESH = 8'h80,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              lfsr_enb,
  input  logic [BYTE_W-1:0] lfsr_q,
  input  logic              pq_full,
  input  logic              pq_empty,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              op_enq,
  output logic [KEY_W-1:0]  op_key,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ops_issued
);

  localparam logic [CNT_W-1:0] NumOpsCnt = CNT_W'(NUM_OPS);

  drv_state_t       state_q, state_d;
  pq_op_t           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decide_enq;

  // Empty outranks full so a queue reporting both still gets an enqueue.
  assign decide_enq = pq_empty | (~pq_full & (lfsr_q < ENQ_THRESH));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if ((state_q != StIdle) && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_d   = '0;
            state_d = StDecide;
          end
        end
        StDecide: begin
          op_d.enq = decide_enq;
          if (decide_enq) begin
            state_d = StKeyHi;
          end else begin
            op_d.key = '0;
            state_d  = StIssue;
          end
        end
        StKeyHi: begin
          op_d.key[KEY_W-1:BYTE_W] = lfsr_q;
          state_d                  = StKeyLo;
        end
        StKeyLo: begin
          op_d.key[BYTE_W-1:0] = lfsr_q;
          state_d              = StIssue;
        end
        StIssue: begin
          if (op_ready) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == NumOpsCnt) ? StDone : StDecide;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // The LFSR consumes exactly one byte in each of the three byte-gathering states.
  assign lfsr_enb   = (state_q == StDecide) || (state_q == StKeyHi) || (state_q == StKeyLo);
  assign op_valid   = (state_q == StIssue);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign op_enq     = op_q.enq;
  assign op_key     = op_q.key;
  assign ops_issued = cnt_q;

endmodule
